// File: rtl/shift_capture_595_if.sv
// shift_capture_595_if
// Bundles the serial 74HC595-style driver lines and the captured parallel
// result of shift_capture_595.
//   sclk_i, data_i, latch_en_i : serial shift clock, data and latch from the driver
//   data_o                     : captured storage-register word (W = 8*NUM_ICS)
//   valid_o                    : one-cycle pulse when data_o updates
//   bit_count_o                : shift edges seen in the latched frame (saturating)
//   frame_err_o                : latched frame length differed from W
//   frame_count_o              : latches since reset (wraps)
// master = driver side (bench), slave = capture block.
interface shift_capture_595_if #(
  parameter int NUM_ICS = 2
);
  localparam int W = 8 * NUM_ICS;

  logic         sclk_i;
  logic         data_i;
  logic         latch_en_i;
  logic [W-1:0] data_o;
  logic         valid_o;
  logic [7:0]   bit_count_o;
  logic         frame_err_o;
  logic [7:0]   frame_count_o;

  modport master (
    output sclk_i, data_i, latch_en_i,
    input  data_o, valid_o, bit_count_o, frame_err_o, frame_count_o
  );

  modport slave (
    input  sclk_i, data_i, latch_en_i,
    output data_o, valid_o, bit_count_o, frame_err_o, frame_count_o
  );
endinterface

// File: rtl/shift_capture_595.sv
// shift_capture_595
// Emulates NUM_ICS cascaded 74HC595 shift/storage registers driven from an
// asynchronous serial source. Serial lines are synchronised into clk_i, edges
// are detected, and the storage register is updated on each latch rising edge.
//   clk_i : system clock, all state on its rising edge
//   rst_i : asynchronous active-high reset, clears all state
//   bus   : shift_capture_595_if slave modport (serial inputs, captured outputs)
module shift_capture_595 #(
  parameter int NUM_ICS     = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  shift_capture_595_if.slave  bus
);
  localparam int W = 8 * NUM_ICS;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFTING  = 2'd1,
    SATURATED = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic [SYNC_STAGES-1:0] r_latch_sync;
  logic                   r_sclk_hist;
  logic                   r_latch_hist;

  logic                   w_sclk_s;
  logic                   w_data_s;
  logic                   w_latch_s;
  logic                   w_sclk_rise;
  logic                   w_latch_rise;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [7:0]             r_cnt;
  logic [7:0]             w_cnt_nxt;
  logic                   w_len_err;

  logic [W-1:0]           r_shift;
  logic [W-1:0]           r_data;
  logic                   r_valid;
  logic [7:0]             r_bit_count;
  logic                   r_frame_err;
  logic [7:0]             r_frame_count;

  // Synchroniser chains (equal depth keeps data aligned with its sclk edge)
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sclk_sync  <= '0;
      r_data_sync  <= '0;
      r_latch_sync <= '0;
      r_sclk_hist  <= 1'b0;
      r_latch_hist <= 1'b0;
    end else begin
      r_sclk_sync  <= {r_sclk_sync[SYNC_STAGES-2:0],  bus.sclk_i};
      r_data_sync  <= {r_data_sync[SYNC_STAGES-2:0],  bus.data_i};
      r_latch_sync <= {r_latch_sync[SYNC_STAGES-2:0], bus.latch_en_i};
      r_sclk_hist  <= r_sclk_sync[SYNC_STAGES-1];
      r_latch_hist <= r_latch_sync[SYNC_STAGES-1];
    end
  end

  assign w_sclk_s     = r_sclk_sync[SYNC_STAGES-1];
  assign w_data_s     = r_data_sync[SYNC_STAGES-1];
  assign w_latch_s    = r_latch_sync[SYNC_STAGES-1];
  assign w_sclk_rise  = w_sclk_s  & ~r_sclk_hist;
  assign w_latch_rise = w_latch_s & ~r_latch_hist;

  // Frame-length FSM: state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Frame-length FSM: next state. A latch coinciding with a shift edge starts
  // the new frame with that edge already counted.
  always_comb begin
    w_state_nxt = r_state;
    if (w_latch_rise) begin
      w_state_nxt = w_sclk_rise ? SHIFTING : IDLE;
    end else if (w_sclk_rise) begin
      case (r_state)
        SATURATED: w_state_nxt = SATURATED;
        default:   w_state_nxt = (r_cnt == 8'd254) ? SATURATED : SHIFTING;
      endcase
    end
  end

  // Frame-length FSM: counter value driven from the state
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_latch_rise) begin
      w_cnt_nxt = w_sclk_rise ? 8'd1 : 8'd0;
    end else if (w_sclk_rise && (r_state != SATURATED)) begin
      w_cnt_nxt = r_cnt + 8'd1;
    end
  end

  assign w_len_err = (32'(r_cnt) != W);

  // Shift and storage registers. The storage register samples r_shift as it
  // stood before this cycle's shift, matching a 595 with tied clocks.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_shift       <= '0;
      r_data        <= '0;
      r_valid       <= 1'b0;
      r_bit_count   <= 8'd0;
      r_frame_err   <= 1'b0;
      r_frame_count <= 8'd0;
    end else begin
      r_valid <= w_latch_rise;
      if (w_sclk_rise) begin
        r_shift <= {r_shift[W-2:0], w_data_s};
      end
      if (w_latch_rise) begin
        r_data        <= r_shift;
        r_bit_count   <= r_cnt;
        r_frame_err   <= w_len_err;
        r_frame_count <= r_frame_count + 8'd1;
      end
    end
  end

  assign bus.data_o        = r_data;
  assign bus.valid_o       = r_valid;
  assign bus.bit_count_o   = r_bit_count;
  assign bus.frame_err_o   = r_frame_err;
  assign bus.frame_count_o = r_frame_count;
endmodule

// File: doc/shift_capture_595.md
SHIFT_CAPTURE_595 -- requirements
Module: shift_capture_595

Parameters
REQ-001 NUM_ICS, default 2: number of emulated cascaded 74HC595 devices; word width W = 8*NUM_ICS.
REQ-002 SYNC_STAGES, default 2: synchronizer flops per serial input; legal range 2..3.

Interface
REQ-003 clk_i  input  1  system clock; all state changes on its rising edge.
REQ-004 rst_i  input  1  reset; asynchronous, active-high.
REQ-005 sclk_i  input  1  serial shift clock from the 595 driver; asynchronous to clk_i.
REQ-006 data_i  input  1  serial data; sampled on sclk_i rising edge.
REQ-007 latch_en_i  input  1  storage-register latch; rising edge transfers the shift register to the output.
REQ-008 data_o  output  W  parallel storage-register contents (emulated Q outputs, last IC in MSBs).
REQ-009 valid_o  output  1  one-cycle pulse when data_o is updated.
REQ-010 bit_count_o  output  8  number of sclk rising edges between the previous latch and this latch, saturating at 255.
REQ-011 frame_err_o  output  1  registered with valid_o; high when bit_count_o != W.
REQ-012 frame_count_o  output  8  count of latches since reset; wraps 255 -> 0.

Function
REQ-013 Each of sclk_i, data_i and latch_en_i SHALL pass through an independent SYNC_STAGES-deep flop chain, plus one history flop on sclk and latch for edge detection.
REQ-014 sclk rise = synchronized sclk 1 while history 0; latch rise is detected the same way; falling edges have no effect.
REQ-015 On sclk rise: shift_reg <= {shift_reg[W-2:0], data_sync}, where data_sync is the synchronized data in the same cycle; the first bit shifted after a latch ends in data_o[W-1] after W shifts.
REQ-016 On sclk rise: the bit counter increments and saturates at 255.
REQ-017 On latch rise:
  - data_o <= shift_reg;
  - bit_count_o <= bit counter;
  - frame_err_o <= (bit counter != W);
  - frame_count_o increments;
  - valid_o = 1 for exactly one cycle;
  - the bit counter clears.
REQ-018 sclk rise and latch rise in the same cycle: latch captures shift_reg before that cycle's shift (595 behaviour with tied clocks); the counter then holds 1, not 0; bit_count_o excludes the simultaneous edge.
REQ-019 shift_reg is not cleared by a latch; bits shifted beyond W are discarded from the MSB end.
REQ-020 Latency, with SYNC_STAGES=2: valid_o and the new data_o appear at the 3rd clk_i rising edge counting the first edge that samples latch_en_i high; each extra sync stage adds 1.
REQ-021 data_o, bit_count_o, frame_err_o and frame_count_o hold their values between latches.
REQ-022 Serial pulse widths (high and low) of at least SYNC_STAGES+1 clk_i periods SHALL be captured without loss; shorter pulses are undefined.
REQ-023 Internal FSM states:
  - IDLE: counter = 0, no edges since the last latch;
  - SHIFTING: counter > 0;
  - SATURATED: counter = 255.
  Any latch rise returns to IDLE, or to SHIFTING under REQ-018.

Reset
REQ-024 While rst_i is high, regardless of clk_i, all of the following SHALL clear:
  - sync chains, history flops, shift_reg and the bit counter;
  - data_o = 0, valid_o = 0, bit_count_o = 0, frame_err_o = 0, frame_count_o = 0.
REQ-025 History flops reset to 0, so an input already high at reset release registers as a rising edge once synchronized; a bench holds inputs low across reset release.
REQ-026 Reset asserted mid-frame discards the partial frame; a latch after release reports only the edges seen after release.

Verification
REQ-027 Nominal frame (NUM_ICS=2): shift 16 bits MSB-first of 0xA5C3, then pulse latch -> data_o = 0xA5C3, valid_o one cycle, bit_count_o = 16, frame_err_o = 0, frame_count_o = 1.
REQ-028 Short frame: 12 bits of 0xABC, then latch -> data_o[11:0] = 0xABC, data_o[15:12] = previous shift_reg[3:0], bit_count_o = 12, frame_err_o = 1.
REQ-029 Overrun and saturation: 300 sclk pulses of data=1, then latch -> data_o = 0xFFFF, bit_count_o = 255, frame_err_o = 1.
REQ-030 Tied clocks: sclk and latch rise together 16 times with data pattern 0x1234:
  - each latch shows shift_reg from before that edge;
  - the final data_o equals 0x1234 shifted by one position less;
  - bit_count_o = 1 on all latches after the first.
REQ-031 Latency and wrap:
  - measure latch-to-valid_o = 3 clk_i edges;
  - issue 256 latches -> frame_count_o returns to 0.
REQ-032 Reset mid-frame:
  - assert rst_i asynchronously after 7 bits -> all outputs 0 immediately;
  - after release, 16 bits of 0x00FF plus latch -> data_o = 0x00FF, frame_count_o = 1.
